// File: rtl/dpram_dma_pkg.sv
// Shared definitions for the dpram block-transfer engine: FSM encoding and mode codes.
// Pure typedefs and constants, no logic, no latency, no flow control.
package dpram_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

endpackage

// File: rtl/dpram_dma.sv
// Fill/copy engine on one dpram port: fill writes 1 word/cycle, copy alternates read/write (2 cycles/word).
// No backpressure: start is only sampled in IDLE, done pulses one cycle after the last write.
module dpram_dma
  import dpram_dma_pkg::*;
#(
  parameter int DATA = 8,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic [ADDR-1:0] src_addr,
  input  logic [ADDR-1:0] dst_addr,
  input  logic [ADDR:0]   len,
  input  logic [DATA-1:0] fill_data,
  output logic            busy,
  output logic            done,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  state_t          r_state;
  logic            r_mode;
  logic [ADDR-1:0] r_src;
  logic [ADDR-1:0] r_dst;
  logic [ADDR:0]   r_cnt;
  logic [DATA-1:0] r_fill;
  logic            r_busy;
  logic            r_done;
  logic            r_mem_wr;
  logic [ADDR-1:0] r_mem_addr;
  logic            w_last;

  // r_cnt holds the words still to write, including the one issued this cycle
  assign w_last = (r_cnt == (ADDR+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_FILL;
      r_src      <= '0;
      r_dst      <= '0;
      r_cnt      <= '0;
      r_fill     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_fill <= fill_data;
            r_cnt  <= len;
            r_src  <= src_addr;
            r_dst  <= dst_addr;
            if (len == '0) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else if (mode == MODE_FILL) begin
              r_state    <= ST_FILL;
              r_busy     <= 1'b1;
              r_mem_wr   <= 1'b1;
              r_mem_addr <= dst_addr;
              r_dst      <= dst_addr + ADDR'(1);
            end else begin
              r_state    <= ST_RD;
              r_busy     <= 1'b1;
              r_mem_wr   <= 1'b0;
              r_mem_addr <= src_addr;
              r_src      <= src_addr + ADDR'(1);
            end
          end
        end
        ST_FILL: begin
          r_cnt <= r_cnt - (ADDR+1)'(1);
          if (w_last) begin
            r_state  <= ST_FIN;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_mem_wr <= 1'b0;
          end else begin
            r_mem_addr <= r_dst;
            r_dst      <= r_dst + ADDR'(1);
          end
        end
        ST_RD: begin
          r_state    <= ST_WR;
          r_mem_wr   <= 1'b1;
          r_mem_addr <= r_dst;
          r_dst      <= r_dst + ADDR'(1);
        end
        ST_WR: begin
          r_cnt <= r_cnt - (ADDR+1)'(1);
          if (w_last) begin
            r_state  <= ST_FIN;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_mem_wr <= 1'b0;
          end else begin
            r_state    <= ST_RD;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= r_src;
            r_src      <= r_src + ADDR'(1);
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_wr   = r_mem_wr;
  assign mem_addr = r_mem_addr;
  // Copy forwards the RAM read data straight into the following write cycle
  assign mem_din  = (r_mode == MODE_COPY) ? mem_dout : r_fill;

endmodule
